// File: rtl/tetrix_disp_pkg.sv
// rtl/tetrix_disp_pkg.sv - shared display constants, scan state encoding and counter sizing helper
package tetrix_disp_pkg;

  // Playfield geometry shared with the game logic
  localparam int DISP_ROWS = 16;
  localparam int DISP_COLS = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    LATCH,
    HOLD
  } scan_state_t;

  // Width of a counter that runs 0 .. terminal-1; never narrower than one bit
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// rtl/sclk_tick_gen.sv - CLK_DIV prescaler producing a one-cycle sclk half-period tick
module sclk_tick_gen
  import tetrix_disp_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int            CW       = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count clk_in cycles within the current half period; clr aligns the first half to SHIFT entry
  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == DIV_LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == DIV_LAST);

endmodule

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - row-multiplexed LED matrix scan driver for a 74HC595 chain (option: MATRIX_SCAN_PWM_EN)
module matrix_scan_driver
  import tetrix_disp_pkg::*;
#(
  parameter int ROWS        = DISP_ROWS,
  parameter int COLS        = DISP_COLS,
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en,
`ifdef MATRIX_SCAN_PWM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [$clog2(ROWS)-1:0] row_addr,
  input  logic [COLS-1:0]         row_data,
  output logic                    sclk,
  output logic                    sdata,
  output logic                    latch,
  output logic                    oe_n,
  output logic [$clog2(ROWS)-1:0] row_sel,
  output logic                    frame_done
);

  localparam int            RW        = $clog2(ROWS);
  localparam int            BW        = cnt_width(COLS);
  localparam int            HW        = cnt_width(HOLD_CYCLES);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(COLS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  scan_state_t     state;
  scan_state_t     state_nx;
  logic [RW-1:0]   row_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [COLS-1:0] shreg;
  logic            half_tick;
  logic            shift_done;
  logic            hold_done;

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_in(clk_in),
    .rst   (rst),
    .clr   (state == LOAD),
    .run   (state == SHIFT),
    .tick  (half_tick)
  );

  // Last bit is done when its high half-period expires
  assign shift_done = (state == SHIFT) && half_tick && sclk && (bit_cnt == BIT_LAST);
  assign hold_done  = (state == HOLD) && (hold_cnt == HOLD_LAST);

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state; en is only looked at in IDLE and at the end of HOLD so a row always completes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (shift_done) state_nx = LATCH;
      LATCH:   state_nx = HOLD;
      HOLD:    if (hold_done) state_nx = en ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Row/bit/hold counters, shift register and serial clock
  always_ff @(posedge clk_in) begin
    if (rst) begin
      row_cnt    <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      shreg      <= '0;
      sclk       <= 1'b0;
      row_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          shreg   <= row_data;
          bit_cnt <= '0;
          sclk    <= 1'b0;
        end
        SHIFT: begin
          if (half_tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling edge: present the next bit while sclk is low
              sclk    <= 1'b0;
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          // Row select switches while the LATCH cycle blanks the display
          if (shift_done) begin
            row_sel <= row_cnt;
          end
        end
        LATCH: begin
          hold_cnt <= '0;
        end
        HOLD: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_done) begin
            row_cnt    <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
            frame_done <= (row_cnt == ROW_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  assign row_addr = row_cnt;
  assign sdata    = shreg[COLS-1];
  assign latch    = (state == LATCH);

`ifdef MATRIX_SCAN_PWM_EN
  localparam int SLICE = HOLD_CYCLES / 16;

  logic [3:0] bright_q;

  // Capture brightness as HOLD is entered so a change cannot split a row's duty cycle
  always_ff @(posedge clk_in) begin
    if (rst) begin
      bright_q <= 4'd0;
    end else if (state == LATCH) begin
      bright_q <= brightness;
    end
  end

  // Lit only during the first bright_q slices of HOLD
  assign oe_n = !((state == HOLD) &&
                  (32'(hold_cnt) < (32'(bright_q) * 32'(SLICE))));
`else
  logic lit;

  // The previous row stays lit from the end of its HOLD until the next LATCH blanks it
  always_ff @(posedge clk_in) begin
    if (rst) begin
      lit <= 1'b0;
    end else if (hold_done && en) begin
      lit <= 1'b1;
    end else if (shift_done) begin
      lit <= 1'b0;
    end
  end

  assign oe_n = !((state == HOLD) || lit);
`endif

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - self-checking bench for matrix_scan_driver (option: MATRIX_SCAN_PWM_EN)
module tb_matrix_scan_driver;

  localparam int ROWS        = 4;
  localparam int COLS        = 8;
  localparam int CLK_DIV     = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int ROW_PERIOD  = 3 + COLS * 2 * CLK_DIV + HOLD_CYCLES;
  localparam int FIRST_LATCH = 3 + COLS * 2 * CLK_DIV;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] row_addr;
  logic [7:0] row_data;
  logic       sclk;
  logic       sdata;
  logic       latch;
  logic       oe_n;
  logic [1:0] row_sel;
  logic       frame_done;
`ifdef MATRIX_SCAN_PWM_EN
  logic [3:0] brightness;
`endif

  matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
`ifdef MATRIX_SCAN_PWM_EN
    .brightness(brightness),
`endif
    .row_addr  (row_addr),
    .row_data  (row_data),
    .sclk      (sclk),
    .sdata     (sdata),
    .latch     (latch),
    .oe_n      (oe_n),
    .row_sel   (row_sel),
    .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  int         n_assert;
  int         n_fail;
  int         cyc;
  int         t0;
  int         lc;
  int         fd0;
  int         exp_row;
  int         rises;
  int         last_latch;
  int         last_fd;
  int         latch_cnt;
  int         fd_cnt;
  bit         track;
  bit         lit_chk;
  logic       prev_sclk;
  logic [7:0] chain;
  logic [7:0] mem [ROWS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: serve the playfield read port, model the 595 chain, and check each latch/frame event
  task automatic step();
    logic [1:0] a;
    a = row_addr;
    @(posedge clk_in);
    #1;
    cyc++;
    row_data = mem[a];
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      chain = {chain[6:0], sdata};
      rises++;
    end
    prev_sclk = sclk;
    if (track) begin
      if (latch === 1'b1) begin
        chk("row_sel", 32'(row_sel), 32'(exp_row));
        chk("row_bits", 32'(chain), 32'(mem[exp_row]));
        chk("sclk_rises", 32'(rises), 32'(COLS));
        if (last_latch >= 0) chk("row_period", 32'(cyc - last_latch), 32'(ROW_PERIOD));
        last_latch = cyc;
        rises      = 0;
        latch_cnt++;
        exp_row    = (exp_row + 1) % ROWS;
        if (en) lit_chk = 1'b1;
      end
      if (frame_done === 1'b1) begin
        chk("fd_row_addr", 32'(row_addr), 32'd0);
        chk("fd_after_last_row", 32'(exp_row), 32'd0);
        if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(ROWS * ROW_PERIOD));
        last_fd = cyc;
        fd_cnt++;
      end
`ifndef MATRIX_SCAN_PWM_EN
      if (lit_chk) chk("oe_n_steady", 32'(oe_n), 32'(latch));
`endif
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; exp_row = 0; rises = 0;
    last_latch = -1; last_fd = -1; latch_cnt = 0; fd_cnt = 0;
    track = 1'b0; lit_chk = 1'b0; prev_sclk = 1'b0; chain = 8'h00;
    rst = 1'b1; en = 1'b1; row_data = 8'h00;
`ifdef MATRIX_SCAN_PWM_EN
    brightness = 4'd0;
`endif
    mem[0] = 8'($urandom);
    mem[1] = 8'hA5;
    mem[2] = 8'hFF;
    mem[3] = 8'h01;

    // Reset held with en high: everything at reset values
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_row_addr", 32'(row_addr), 32'd0);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_sdata", 32'(sdata), 32'd0);
      chk("rst_latch", 32'(latch), 32'd0);
      chk("rst_oe_n", 32'(oe_n), 32'd1);
      chk("rst_row_sel", 32'(row_sel), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
    end

    // First latch latency after release
    rst = 1'b0; track = 1'b1; t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      step();
      if (latch === 1'b1) break;
    end
    chk("first_latch_delay", 32'(cyc - t0), 32'(FIRST_LATCH));

    // Continuous scan over three frames, fresh random rows each frame
    for (int i = 0; i < 1000 && latch_cnt < 13; i++) begin
      step();
      if (frame_done === 1'b1) begin
        for (int k = 0; k < ROWS; k++) mem[k] = 8'($urandom);
      end
    end
    chk("latches_3frames", 32'(latch_cnt), 32'd13);
    chk("frames_done", 32'(fd_cnt), 32'd3);

    // Drop en during the SHIFT of row 1
    for (int i = 0; i < 300; i++) begin
      step();
      if (row_addr === 2'd1 && rises >= 2 && latch === 1'b0) break;
    end
    chk("reach_row1_shift", 32'(row_addr), 32'd1);
    en = 1'b0; lit_chk = 1'b0; lc = latch_cnt;
    for (int i = 0; i < 100; i++) begin
      step();
      if (latch === 1'b1) break;
    end
    chk("row1_latched", 32'(latch_cnt), 32'(lc + 1));
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      step();
`ifndef MATRIX_SCAN_PWM_EN
      chk("row1_hold_lit", 32'(oe_n), 32'd0);
`endif
    end
    for (int i = 0; i < 40; i++) begin
      step();
      chk("idle_blank", 32'(oe_n), 32'd1);
    end
    chk("no_latch_idle", 32'(latch_cnt), 32'(lc + 1));
    chk("row_counter_kept", 32'(row_addr), 32'd2);

    // Re-enable: resumes at row 2
    last_latch = -1; last_fd = -1; en = 1'b1; t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      step();
      if (latch === 1'b1) break;
    end
    chk("resume_delay", 32'(cyc - t0), 32'(FIRST_LATCH));
    chk("resume_row", 32'(row_sel), 32'd2);

    // Reset in the middle of HOLD
    for (int i = 0; i < 5; i++) step();
`ifndef MATRIX_SCAN_PWM_EN
    chk("pre_reset_lit", 32'(oe_n), 32'd0);
`endif
    lit_chk = 1'b0; rst = 1'b1;
    step();
    chk("midrst_oe_n", 32'(oe_n), 32'd1);
    chk("midrst_row_sel", 32'(row_sel), 32'd0);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_row_addr", 32'(row_addr), 32'd0);
    step();
    step();
    rst = 1'b0; exp_row = 0; rises = 0; last_latch = -1; last_fd = -1; t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      step();
      if (latch === 1'b1) break;
    end
    chk("restart_delay", 32'(cyc - t0), 32'(FIRST_LATCH));
    chk("restart_row", 32'(row_sel), 32'd0);
    fd0 = fd_cnt;
    for (int i = 0; i < 400 && fd_cnt == fd0; i++) step();
    chk("restart_frame_done", 32'(fd_cnt), 32'(fd0 + 1));

`ifdef MATRIX_SCAN_PWM_EN
    // Brightness: low cycles per row period equal brightness (one cycle per slice here)
    for (int r = 0; r < 6; r++) begin
      int b;
      int lows;
      b = (r == 0) ? 4 : (r == 1) ? 0 : int'($urandom_range(0, 15));
      brightness = 4'(b);
      for (int i = 0; i < 100; i++) begin
        step();
        if (latch === 1'b1) break;
      end
      lows = 0;
      for (int i = 0; i < ROW_PERIOD; i++) begin
        step();
        if (oe_n === 1'b0) lows++;
      end
      chk("pwm_low_cycles", 32'(lows), 32'(b));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
